doubler_arbiter: RTL and testbench

- Shares one doubler datapath (rsp = cmd + cmd, truncated to WIDTH) between PORTS independent requesters.
- Round-robin grant, valid/ready handshake on every requester and on the single response channel.
- One-entry registered output: 1-cycle latency, full throughput.
- Sits between several producer blocks and one consumer, and replaces per-requester copies of the doubler.

---
 rtl/doubler_arbiter_pkg.sv | 17 +
 rtl/rr_picker.sv | 30 +++
 rtl/doubler_arbiter.sv | 102 ++++++++++
 tb/tb_doubler_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/doubler_arbiter_pkg.sv
// Shared definitions for the doubler arbiter: default data width,
// the wrap-around doubling function and the response-slot states.
package doubler_arbiter_pkg;

  localparam int DBL_WIDTH = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  // Callers truncate the result to their own width, which drops the carry.
  function automatic logic [31:0] double_wrap(input logic [31:0] cmd);
    return cmd + cmd;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first request found searching upward
// from last_grant+1 with wrap. Reusable by any arbiter.
module rr_picker #(
  parameter int PORTS = 4,
  parameter int ID_W  = 2
) (
  input  logic [PORTS-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [PORTS-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_grant
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = (int'(last_grant) + k) % PORTS;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/doubler_arbiter.sv
// Round-robin arbiter sharing one doubler datapath between PORTS requesters,
// with a single registered response slot (1-cycle latency, full throughput).
module doubler_arbiter
  import doubler_arbiter_pkg::*;
#(
  parameter int WIDTH = DBL_WIDTH,
  parameter int PORTS = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PORTS-1:0]       req_valid,
  input  logic [PORTS*WIDTH-1:0] req_data,
  output logic [PORTS-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_ready,
  output logic                   busy,
  output logic [CNT_W-1:0]       served_count
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0] served_count_q, served_count_d;

  logic             slot_free;
  logic [PORTS-1:0] pick_req;
  logic [PORTS-1:0] grant;
  logic [ID_W-1:0]  win_idx;
  logic             accept;
  logic [WIDTH-1:0] win_cmd;
  logic [WIDTH-1:0] win_dbl;

  assign slot_free = (state_q == EMPTY) || rsp_ready;
  // Masking with reset keeps req_ready low for the whole reset assertion.
  assign pick_req  = (slot_free && !reset) ? req_valid : '0;

  rr_picker #(
    .PORTS(PORTS),
    .ID_W (ID_W)
  ) u_picker (
    .req       (pick_req),
    .last_grant(last_grant_q),
    .grant     (grant),
    .grant_idx (win_idx),
    .any_grant (accept)
  );

  always_comb begin
    win_cmd = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant[i]) win_cmd = req_data[i*WIDTH +: WIDTH];
    end
    win_dbl = WIDTH'(double_wrap(32'(win_cmd)));
  end

  always_comb begin
    state_d        = state_q;
    rsp_data_d     = rsp_data_q;
    rsp_id_d       = rsp_id_q;
    last_grant_d   = last_grant_q;
    served_count_d = served_count_q;
    if (accept) begin
      state_d        = FULL;
      rsp_data_d     = win_dbl;
      rsp_id_d       = win_idx;
      last_grant_d   = win_idx;
      served_count_d = served_count_q + CNT_W'(1);
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // last_grant resets to PORTS-1 so port 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= EMPTY;
      rsp_data_q     <= '0;
      rsp_id_q       <= '0;
      last_grant_q   <= ID_W'(PORTS - 1);
      served_count_q <= '0;
    end else begin
      state_q        <= state_d;
      rsp_data_q     <= rsp_data_d;
      rsp_id_q       <= rsp_id_d;
      last_grant_q   <= last_grant_d;
      served_count_q <= served_count_d;
    end
  end

  assign req_ready    = grant;
  assign rsp_valid    = (state_q == FULL);
  assign rsp_data     = rsp_data_q;
  assign rsp_id       = rsp_id_q;
  assign served_count = served_count_q;
  assign busy         = rsp_valid || (|req_valid);

endmodule

// File: tb/tb_doubler_arbiter.sv
// Scoreboard bench for doubler_arbiter: stimulus pushes hand-computed
// responses, a negedge monitor pops and compares on each response handshake.
module tb_doubler_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [3:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready;
  logic        busy;
  logic [15:0] served_count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] data;
  } exp_t;

  exp_t exp_q[$];

  doubler_arbiter #(
    .WIDTH(4),
    .PORTS(4),
    .ID_W (2),
    .CNT_W(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .rsp_ready   (rsp_ready),
    .busy        (busy),
    .served_count(served_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of inputs, checks the grant at the negedge and records
  // the response the grant should produce.
  task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] data,
                               input logic ready, input logic [3:0] exp_ready,
                               input logic [1:0] exp_id, input logic [3:0] exp_data);
    exp_t e;
    req_valid = valid;
    req_data  = data;
    rsp_ready = ready;
    @(negedge clk);
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    if (exp_ready != 4'b0000) begin
      e.id   = exp_id;
      e.data = exp_data;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rsp actual=id%0d/%0h expected=none", rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
        checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // Reset held with all requesters valid
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_data  = 16'h4321;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_served", 32'(served_count), 32'h0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'h0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(4'b1111, 16'h4321, 1'b1, 4'b0001, 2'd0, 4'h2);
    checkOutput("t1_rsp_valid_pre", 32'(rsp_valid), 32'h0);
    nextCycle();
    applyStimulus(4'b0000, 16'h0000, 1'b1, 4'b0000, 2'd0, 4'h0);
    checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t1_served", 32'(served_count), 32'd1);

    // Lone requester on port 2; previous response drained without reload
    nextCycle();
    applyStimulus(4'b0100, 16'h0500, 1'b1, 4'b0100, 2'd2, 4'hA);
    checkOutput("t2_drained_valid", 32'(rsp_valid), 32'h0);
    checkOutput("t2_drained_data_hold", 32'(rsp_data), 32'h2);
    nextCycle();
    applyStimulus(4'b0000, 16'h0000, 1'b1, 4'b0000, 2'd0, 4'h0);
    checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t2_rsp_data", 32'(rsp_data), 32'hA);
    checkOutput("t2_rsp_id", 32'(rsp_id), 32'd2);
    checkOutput("t2_served", 32'(served_count), 32'd2);

    // Carry dropped: 9+9 = 18 -> 2
    nextCycle();
    applyStimulus(4'b0010, 16'h0090, 1'b1, 4'b0010, 2'd1, 4'h2);
    nextCycle();
    applyStimulus(4'b0000, 16'h0000, 1'b1, 4'b0000, 2'd0, 4'h0);
    checkOutput("t3_rsp_data", 32'(rsp_data), 32'h2);
    checkOutput("t3_rsp_id", 32'(rsp_id), 32'd1);
    checkOutput("t3_served", 32'(served_count), 32'd3);

    // Grant port 3 so the rotation below starts at port 0
    nextCycle();
    applyStimulus(4'b1000, 16'h7000, 1'b1, 4'b1000, 2'd3, 4'hE);

    // All four valid: grants rotate 0,1,2,3 twice, data 2,4,6,8
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      applyStimulus(4'b1111, 16'h4321, 1'b1, 4'(1 << (i % 4)), 2'(i % 4), 4'(2 * ((i % 4) + 1)));
      checkOutput("t4_rsp_valid", 32'(rsp_valid), 32'h1);
    end

    // Backpressure: port 0 accepted, then held for three stalled cycles
    nextCycle();
    applyStimulus(4'b1001, 16'h5003, 1'b1, 4'b0001, 2'd0, 4'h6);
    checkOutput("t4_served", 32'(served_count), 32'd12);
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      applyStimulus(4'b1001, 16'h5003, 1'b0, 4'b0000, 2'd0, 4'h0);
      checkOutput("t5_stall_valid", 32'(rsp_valid), 32'h1);
      checkOutput("t5_stall_data", 32'(rsp_data), 32'h6);
      checkOutput("t5_stall_id", 32'(rsp_id), 32'd0);
    end
    nextCycle();
    applyStimulus(4'b1001, 16'h5003, 1'b1, 4'b1000, 2'd3, 4'hA);
    nextCycle();
    applyStimulus(4'b0001, 16'h0003, 1'b1, 4'b0001, 2'd0, 4'h6);
    checkOutput("t5_nobubble_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t5_nobubble_id", 32'(rsp_id), 32'd3);
    checkOutput("t5_served", 32'(served_count), 32'd14);

    // Asynchronous reset while a response is pending
    nextCycle();
    applyStimulus(4'b0011, 16'h0021, 1'b0, 4'b0000, 2'd0, 4'h0);
    checkOutput("t6_pending_valid", 32'(rsp_valid), 32'h1);
    #2;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checkOutput("t6_async_valid", 32'(rsp_valid), 32'h0);
    checkOutput("t6_async_served", 32'(served_count), 32'h0);
    checkOutput("t6_async_req_ready", 32'(req_ready), 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(4'b0011, 16'h0021, 1'b1, 4'b0001, 2'd0, 4'h2);
    nextCycle();
    applyStimulus(4'b0000, 16'h0000, 1'b1, 4'b0000, 2'd0, 4'h0);
    checkOutput("t6_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("t6_served", 32'(served_count), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("end_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("end_busy", 32'(busy), 32'h0);
    checkOutput("end_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
